store_queue: RTL and testbench

Circular store queue serving the load functional unit and the data cache. It allocates entries for stores at dispatch and records their addresses and data when the store functional unit executes them. It drains committed stores to the cache in program order, and answers load lookups combinationally with per-byte store-to-load forwarding or a stall.

---
 rtl/store_queue.sv | 153 +++++++++++++++
 tb/tb_store_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// Circular store queue: allocates stores at dispatch, records address/data at
// execute, drains committed stores to the cache in order, and answers load
// lookups combinationally with per-byte forwarding or a stall.
module store_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  localparam int IDX  = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            disp_valid,
  output logic [IDX-1:0]  disp_idx,
  output logic            sq_full,
  input  logic            exe_valid,
  input  logic [IDX-1:0]  exe_idx,
  input  logic [XLEN-1:0] exe_addr,
  input  logic [XLEN-1:0] exe_data,
  input  logic [3:0]      exe_usebytes,
  input  logic            commit_valid,
  input  logic            squash,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [IDX-1:0]  ld_tail_pos,
  output logic            ld_stall,
  output logic [3:0]      ld_usebytes,
  output logic [XLEN-1:0] ld_data,
  output logic            cache_wr_valid,
  output logic [XLEN-1:0] cache_wr_addr,
  output logic [XLEN-1:0] cache_wr_data,
  output logic [3:0]      cache_wr_bytes,
  input  logic            cache_wr_ready
);

  logic [IDX-1:0] head, commit_ptr, tail;
  logic [IDX:0]   count, ncommit;

  logic [DEPTH-1:0]           valid, resolved;
  logic [DEPTH-1:0][XLEN-3:0] addr;
  logic [DEPTH-1:0][XLEN-1:0] data;
  logic [DEPTH-1:0][3:0]      bytes;

  logic disp_fire, exe_fire, commit_fire, drain_fire;
  logic [IDX:0] ncommit_keep, ncommit_nxt;
  logic [DEPTH-1:0] kill;

  // word offset bits are never used; the lookup and storage are word-granular
  logic unused_low;
  assign unused_low = ^{exe_addr[1:0], ld_addr[1:0]};

  assign sq_full  = (count == (IDX+1)'(DEPTH));
  assign disp_idx = tail;

  assign disp_fire   = disp_valid && !sq_full && !squash;
  assign exe_fire    = exe_valid && valid[exe_idx] && !squash;
  assign commit_fire = commit_valid && (ncommit < count);
  assign drain_fire  = cache_wr_valid && cache_wr_ready;

  // committed entries that survive a squash (drain still removes the head)
  assign ncommit_keep = ncommit + (IDX+1)'(commit_fire);
  assign ncommit_nxt  = ncommit_keep - (IDX+1)'(drain_fire);

  // squash kills every entry at or beyond the post-commit commit point
  for (genvar g = 0; g < DEPTH; g++) begin : g_kill
    logic [IDX-1:0] off;
    assign off     = IDX'(g) - head;
    assign kill[g] = squash && ({1'b0, off} >= ncommit_keep);
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
      count      <= '0;
      ncommit    <= '0;
    end else begin
      head       <= head + IDX'(drain_fire);
      commit_ptr <= commit_ptr + IDX'(commit_fire);
      ncommit    <= ncommit_nxt;
      if (squash) begin
        tail  <= commit_ptr + IDX'(commit_fire);
        count <= ncommit_nxt;
      end else begin
        tail  <= tail + IDX'(disp_fire);
        count <= count + (IDX+1)'(disp_fire) - (IDX+1)'(drain_fire);
      end
    end
  end

  // per-entry state: clear on squash/drain, allocate at tail, fill on execute
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid    <= '0;
      resolved <= '0;
      addr     <= '0;
      data     <= '0;
      bytes    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i] || (drain_fire && head == IDX'(i))) begin
          valid[i]    <= 1'b0;
          resolved[i] <= 1'b0;
        end else if (disp_fire && tail == IDX'(i)) begin
          valid[i]    <= 1'b1;
          resolved[i] <= 1'b0;
        end else if (exe_fire && exe_idx == IDX'(i)) begin
          resolved[i] <= 1'b1;
          addr[i]     <= exe_addr[XLEN-1:2];
          data[i]     <= exe_data;
          bytes[i]    <= exe_usebytes;
        end
      end
    end
  end

  // drain port: outputs read zero whenever nothing is offered
  assign cache_wr_valid = (ncommit != '0) && resolved[head];
  assign cache_wr_addr  = cache_wr_valid ? {addr[head], 2'b00} : '0;
  assign cache_wr_data  = cache_wr_valid ? data[head] : '0;
  assign cache_wr_bytes = cache_wr_valid ? bytes[head] : '0;

  logic [IDX-1:0]  span, li;
  logic [3:0]      fwd_bytes;
  logic [XLEN-1:0] fwd_data;

  // load lookup: walk older stores oldest->youngest so younger bytes overwrite
  always_comb begin
    ld_stall  = 1'b0;
    fwd_bytes = '0;
    fwd_data  = '0;
    li        = '0;
    span      = ld_tail_pos - head;
    for (int k = 0; k < DEPTH; k++) begin
      li = head + IDX'(k);
      if (IDX'(k) < span && valid[li]) begin
        if (!resolved[li]) begin
          ld_stall = 1'b1;
        end else if (addr[li] == ld_addr[XLEN-1:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (bytes[li][b]) begin
              fwd_bytes[b]       = 1'b1;
              fwd_data[8*b +: 8] = data[li][8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign ld_usebytes = ld_stall ? 4'b0 : fwd_bytes;
  assign ld_data     = ld_stall ? '0 : fwd_data;

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios plus randomized traffic checked
// against a program-ordered queue model of the store queue.
module tb_store_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int IDX   = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            disp_valid;
  logic [IDX-1:0]  disp_idx;
  logic            sq_full;
  logic            exe_valid;
  logic [IDX-1:0]  exe_idx;
  logic [XLEN-1:0] exe_addr, exe_data;
  logic [3:0]      exe_usebytes;
  logic            commit_valid, squash;
  logic [XLEN-1:0] ld_addr;
  logic [IDX-1:0]  ld_tail_pos;
  logic            ld_stall;
  logic [3:0]      ld_usebytes;
  logic [XLEN-1:0] ld_data;
  logic            cache_wr_valid;
  logic [XLEN-1:0] cache_wr_addr, cache_wr_data;
  logic [3:0]      cache_wr_bytes;
  logic            cache_wr_ready;

  store_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_idx(disp_idx), .sq_full(sq_full),
    .exe_valid(exe_valid), .exe_idx(exe_idx), .exe_addr(exe_addr),
    .exe_data(exe_data), .exe_usebytes(exe_usebytes),
    .commit_valid(commit_valid), .squash(squash),
    .ld_addr(ld_addr), .ld_tail_pos(ld_tail_pos), .ld_stall(ld_stall),
    .ld_usebytes(ld_usebytes), .ld_data(ld_data),
    .cache_wr_valid(cache_wr_valid), .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data), .cache_wr_bytes(cache_wr_bytes),
    .cache_wr_ready(cache_wr_ready)
  );

  always #5 clock = ~clock;

  // model: stores kept in program order, oldest at the front
  typedef struct {
    int         id;
    bit         res;
    bit [31:0]  a;
    bit [31:0]  d;
    bit [3:0]   be;
    bit         com;
  } st_t;
  st_t sq[$];
  int  m_head, m_tail;
  int  n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // older stores are those ahead of the entry whose id equals the load's tail
  task automatic model_ld(output bit stall, output bit [3:0] ub, output bit [31:0] dat);
    bit done = 0;
    stall = 0; ub = 0; dat = 0;
    for (int i = 0; i < sq.size(); i++) begin
      if (sq[i].id == int'(ld_tail_pos)) done = 1;
      if (!done) begin
        if (!sq[i].res) stall = 1;
        else if (sq[i].a[31:2] == ld_addr[31:2])
          for (int b = 0; b < 4; b++)
            if (sq[i].be[b]) begin ub[b] = 1; dat[8*b +: 8] = sq[i].d[8*b +: 8]; end
      end
    end
    if (stall) begin ub = 0; dat = 0; end
  endtask

  task automatic check_outs();
    bit st; bit [3:0] ub; bit [31:0] dd; bit ev;
    chk("disp_idx", 32'(disp_idx), 32'(m_tail));
    chk("sq_full", 32'(sq_full), 32'(sq.size() == DEPTH));
    ev = 0;
    if (sq.size() > 0) ev = sq[0].com && sq[0].res;
    chk("wr_valid", 32'(cache_wr_valid), 32'(ev));
    if (ev) begin
      chk("wr_addr", cache_wr_addr, {sq[0].a[31:2], 2'b00});
      chk("wr_data", cache_wr_data, sq[0].d);
      chk("wr_bytes", 32'(cache_wr_bytes), 32'(sq[0].be));
    end
    model_ld(st, ub, dd);
    chk("ld_stall", 32'(ld_stall), 32'(st));
    chk("ld_usebytes", 32'(ld_usebytes), 32'(ub));
    chk("ld_data", ld_data, dd);
  endtask

  // apply this cycle's inputs to the model, all decisions from pre-edge state
  task automatic model_edge();
    int  pre = sq.size();
    bit  drain = 0, found = 0;
    if (pre > 0) drain = sq[0].com && sq[0].res && cache_wr_ready;
    if (commit_valid)
      for (int i = 0; i < sq.size(); i++)
        if (!found && !sq[i].com) begin sq[i].com = 1; found = 1; end
    if (squash) begin
      while (sq.size() > 0 && !sq[sq.size()-1].com) sq.delete(sq.size()-1);
      m_tail = (m_head + sq.size()) % DEPTH;
    end else begin
      if (exe_valid)
        for (int i = 0; i < sq.size(); i++)
          if (sq[i].id == int'(exe_idx)) begin
            sq[i].res = 1; sq[i].a = exe_addr; sq[i].d = exe_data; sq[i].be = exe_usebytes;
          end
      if (disp_valid && pre < DEPTH) begin
        sq.push_back('{id: m_tail, default: 0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    if (drain) begin
      sq.delete(0);
      m_head = (m_head + 1) % DEPTH;
    end
  endtask

  // inputs are set at the falling edge; check, then clock, then update model
  task automatic cyc();
    #1 check_outs();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle();
    disp_valid = 0; exe_valid = 0; exe_idx = 0; exe_addr = 0; exe_data = 0;
    exe_usebytes = 0; commit_valid = 0; squash = 0; cache_wr_ready = 0;
    ld_addr = 0; ld_tail_pos = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    sq.delete(); m_head = 0; m_tail = 0;
    #1;
    chk("rst_disp_idx", 32'(disp_idx), 0);
    chk("rst_sq_full", 32'(sq_full), 0);
    chk("rst_wr_valid", 32'(cache_wr_valid), 0);
    chk("rst_wr_addr", cache_wr_addr, 0);
    chk("rst_wr_data", cache_wr_data, 0);
    chk("rst_wr_bytes", 32'(cache_wr_bytes), 0);
    chk("rst_ld_stall", 32'(ld_stall), 0);
    chk("rst_ld_usebytes", 32'(ld_usebytes), 0);
    chk("rst_ld_data", ld_data, 0);
    @(negedge clock);
    reset = 1;
  endtask

  task automatic exe(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exe_valid = 1; exe_idx = IDX'(idx); exe_addr = a; exe_data = d; exe_usebytes = be;
    cyc();
    exe_valid = 0;
  endtask

  task automatic dispatch(input int n);
    for (int k = 0; k < n; k++) begin disp_valid = 1; cyc(); end
    disp_valid = 0;
  endtask

  logic [31:0] pool [3] = '{32'h100, 32'h104, 32'h200};
  logic [31:0] cap_a, cap_d;
  logic [3:0]  cap_b;

  initial begin
    n_cmp = 0; n_err = 0;
    idle();
    do_reset();

    // dispatch indices and full flag
    for (int k = 0; k < 3; k++) begin
      disp_valid = 1;
      #1 chk("disp_seq", 32'(disp_idx), 32'(k));
      cyc();
    end
    disp_valid = 0;
    #1 chk("full_at3", 32'(sq_full), 0);
    dispatch(5);
    #1 chk("full_at8", 32'(sq_full), 1);

    // whole-word forward
    exe(0, 32'h100, 32'hDEADBEEF, 4'b1111);
    ld_addr = 32'h100; ld_tail_pos = 1;
    #1;
    chk("fw_stall", 32'(ld_stall), 0);
    chk("fw_usebytes", 32'(ld_usebytes), 32'hF);
    chk("fw_data", ld_data, 32'hDEADBEEF);
    cyc();

    // youngest older store wins per byte
    exe(0, 32'h200, 32'h11223344, 4'b1111);
    exe(1, 32'h200, 32'h0000AA00, 4'b0010);
    ld_addr = 32'h200; ld_tail_pos = 2;
    #1 chk("yw_tp2", ld_data, 32'h1122AA44);
    ld_tail_pos = 1;
    #1 chk("yw_tp1", ld_data, 32'h11223344);
    cyc();

    // stall on an older unresolved store
    do_reset();
    dispatch(2);
    exe(1, 32'h300, 32'h55667788, 4'b0011);
    ld_addr = 32'h300; ld_tail_pos = 2;
    #1;
    chk("st_stall", 32'(ld_stall), 1);
    chk("st_usebytes", 32'(ld_usebytes), 0);
    ld_tail_pos = 0;
    #1;
    chk("st_none_stall", 32'(ld_stall), 0);
    chk("st_none_usebytes", 32'(ld_usebytes), 0);
    cyc();

    // drain handshake with back-pressure
    exe(0, 32'h300, 32'hCAFEF00D, 4'b0101);
    ld_tail_pos = 2;
    #1 chk("pre_drain_fw", ld_data, 32'h00FE7788);
    commit_valid = 1; cyc(); commit_valid = 0;
    #1 chk("drain_valid", 32'(cache_wr_valid), 1);
    cap_a = cache_wr_addr; cap_d = cache_wr_data; cap_b = cache_wr_bytes;
    chk("drain_addr", cap_a, 32'h300);
    for (int k = 0; k < 3; k++) begin
      cache_wr_ready = 0; cyc();
      chk("hold_addr", cache_wr_addr, cap_a);
      chk("hold_data", cache_wr_data, cap_d);
      chk("hold_bytes", 32'(cache_wr_bytes), 32'(cap_b));
    end
    cache_wr_ready = 1; cyc(); cache_wr_ready = 0;
    #1;
    chk("post_drain_valid", 32'(cache_wr_valid), 0);
    chk("post_drain_fw", ld_data, 32'h00007788);
    chk("post_drain_ub", 32'(ld_usebytes), 32'h3);
    dispatch(6);
    #1 chk("cnt_after_drain7", 32'(sq_full), 0);
    dispatch(1);
    #1 chk("cnt_after_drain8", 32'(sq_full), 1);

    // reset discards a committed, undrained store
    commit_valid = 1; cyc(); commit_valid = 0;
    #1 chk("pre_rst_valid", 32'(cache_wr_valid), 1);
    do_reset();
    #1 chk("post_rst_valid", 32'(cache_wr_valid), 0);

    // squash then wrap-around dispatch
    dispatch(8);
    for (int k = 0; k < 8; k++) exe(k, pool[$urandom % 3], $urandom, 4'($urandom));
    commit_valid = 1; cyc(); cyc(); commit_valid = 0;
    squash = 1; cyc(); squash = 0;
    #1;
    chk("sq_tail", 32'(disp_idx), 2);
    chk("sq_full_after", 32'(sq_full), 0);
    cache_wr_ready = 1; cyc(); cyc(); cache_wr_ready = 0;
    #1 chk("sq_drained", 32'(cache_wr_valid), 0);
    for (int k = 0; k < 8; k++) begin
      disp_valid = 1;
      #1 chk("wrap_seq", 32'(disp_idx), 32'((2 + k) % 8));
      cyc();
    end
    disp_valid = 0;
    #1 chk("wrap_full", 32'(sq_full), 1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      disp_valid     = ($urandom % 3) != 0;
      exe_valid      = ($urandom % 2) != 0;
      exe_idx        = IDX'($urandom);
      exe_addr       = pool[$urandom % 3] | ($urandom % 4);
      exe_data       = $urandom;
      exe_usebytes   = 4'($urandom);
      commit_valid   = ($urandom % 3) == 0;
      squash         = ($urandom % 25) == 0;
      cache_wr_ready = ($urandom % 2) != 0;
      ld_addr        = pool[$urandom % 3];
      ld_tail_pos    = ($urandom % 2) != 0 ? IDX'(m_tail) : IDX'($urandom);
      cyc();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
